// File: rtl/booth_io_ctrl.sv
// Valid/ready wrapper around a Booth multiplier core: accepts operand pairs, fires one start pulse, holds the product for downstream.
// Optional BUSY watchdog with a sticky err flag is enabled by defining BOOTH_IO_TIMEOUT_EN.
module booth_io_ctrl #(
   parameter int N       = 8,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic           core_valid,
   output logic [N-1:0]   core_a,
   output logic [N-1:0]   core_b,
   input  logic           core_done,
   input  logic [2*N-1:0] core_product,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_product,
   output logic           busy,
   output logic           err
);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_START, S_BUSY} state_t;

   state_t         r_state;
   state_t         w_state_next;
   logic [N-1:0]   r_a;
   logic [N-1:0]   r_b;
   logic [2*N-1:0] r_product;
   logic           r_valid;
   logic           w_slot_empty;
   logic           w_accept;
   logic           w_capture;
   logic           w_timeout;

   // A result being drained this cycle already counts as a free slot.
   assign w_slot_empty = !r_valid || out_ready;
   assign w_accept     = in_valid && (r_state == S_IDLE);
   assign w_capture    = core_done && (r_state == S_BUSY);

`ifdef BOOTH_IO_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;
   logic          r_err;

   // A core_done arriving on the last allowed cycle takes priority over the abort.
   assign w_timeout = (r_state == S_BUSY) && !core_done && (r_cnt == CW'(TIMEOUT - 1));
   assign err       = r_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state == S_START)
            r_cnt <= '0;
         else if (r_state == S_BUSY)
            r_cnt <= r_cnt + CW'(1);
         if (w_timeout)
            r_err <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      core_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               w_state_next = w_slot_empty ? S_START : S_PEND;
         end
         S_PEND: begin
            if (w_slot_empty)
               w_state_next = S_START;
         end
         S_START: begin
            core_valid   = 1'b1;
            w_state_next = S_BUSY;
         end
         S_BUSY: begin
            if (core_done || w_timeout)
               w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_product <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_a <= in_a;
            r_b <= in_b;
         end
         // Capture wins over drain, so a coinciding pair leaves the slot full with the new product.
         if (w_capture) begin
            r_product <= core_product;
            r_valid   <= 1'b1;
         end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign core_a      = r_a;
   assign core_b      = r_b;
   assign out_valid   = r_valid;
   assign out_product = r_product;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_booth_io_ctrl.sv
// Directed bench for booth_io_ctrl: scoreboard queue of expected products, bench-driven core model.
// Timeout expectations follow whether BOOTH_IO_TIMEOUT_EN is defined for the build.
module tb_booth_io_ctrl;
   localparam int N       = 8;
   localparam int TIMEOUT = 16;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_a;
   logic [N-1:0]  in_b;
   logic          core_valid;
   logic [N-1:0]  core_a;
   logic [N-1:0]  core_b;
   logic          core_done;
   logic [15:0]   core_product;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_product;
   logic          busy;
   logic          err;

   int            n_checks;
   int            n_fail;
   logic [15:0]   exp_q[$];

   booth_io_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .core_valid  (core_valid),
      .core_a      (core_a),
      .core_b      (core_b),
      .core_done   (core_done),
      .core_product(core_product),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .busy        (busy),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] sa;
      logic signed [15:0] sb;
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return 16'(sa * sb);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand pair for exactly one cycle and record its expected product.
   task automatic send(input string tag, input logic [7:0] a, input logic [7:0] b);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      exp_q.push_back(smul(a, b));
      $display("[%0t] %s: send a=%0h b=%0h expect %0h", $time, tag, a, b, smul(a, b));
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_launch(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input int max_wait);
      int k;
      k = 0;
      while (!core_valid && k < 20) begin
         tick();
         k++;
      end
      check({tag, "_launch"}, 32'(core_valid), 32'd1);
      check({tag, "_launch_lat"}, 32'(k <= max_wait), 32'd1);
      check({tag, "_core_a"}, 32'(core_a), 32'(a));
      check({tag, "_core_b"}, 32'(core_b), 32'(b));
   endtask

   // Core model: waits delay BUSY cycles, then pulses done with the product of the presented operands.
   task automatic reply(input string tag, input int delay);
      tick();
      check({tag, "_pulse_1cyc"}, 32'(core_valid), 32'd0);
      repeat (delay) tick();
      core_done    = 1'b1;
      core_product = smul(core_a, core_b);
      tick();
      core_done    = 1'b0;
      core_product = 16'h0000;
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
   endtask

   task automatic pop_compare(input string tag);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_product"}, 32'(out_product), 32'(e));
         $display("[%0t] %s: product %0h expected %0h", $time, tag, out_product, e);
      end
   endtask

   task automatic drain(input string tag);
      check({tag, "_drain_valid"}, 32'(out_valid), 32'd1);
      pop_compare(tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_drained"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b0;
      in_valid     = 1'b0;
      in_a         = '0;
      in_b         = '0;
      core_done    = 1'b0;
      core_product = '0;
      out_ready    = 1'b0;
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_core_valid", 32'(core_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_out_product", 32'(out_product), 32'd0);
      check("rst_core_a", 32'(core_a), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Basic: 3 * -4 with downstream ready.
      out_ready = 1'b1;
      send("t1", 8'h03, 8'hFC);
      wait_launch("t1", 8'h03, 8'hFC, 0);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_in_ready", 32'(in_ready), 32'd0);
      reply("t1", 2);
      check("t1_const", 32'(out_product), 32'h0000FFF4);
      pop_compare("t1");
      tick();
      check("t1_drained", 32'(out_valid), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);
      out_ready = 1'b0;

      // Back-to-back with the slot full: second pair waits in PEND.
      send("t2a", 8'h02, 8'h03);
      wait_launch("t2a", 8'h02, 8'h03, 0);
      reply("t2a", 1);
      send("t2b", 8'h07, 8'h05);
      check("t2_pend_busy", 32'(busy), 32'd1);
      check("t2_pend_nolaunch", 32'(core_valid), 32'd0);
      in_valid = 1'b1;
      in_a     = 8'hAA;
      in_b     = 8'h55;
      tick();
      tick();
      in_valid = 1'b0;
      check("t2_pend_nolaunch2", 32'(core_valid), 32'd0);
      check("t2_hold_valid", 32'(out_valid), 32'd1);
      check("t2_hold_product", 32'(out_product), 32'h00000006);
      out_ready = 1'b1;
      pop_compare("t2a");
      tick();
      out_ready = 1'b0;
      check("t2b_launch_after_drain", 32'(core_valid), 32'd1);
      check("t2b_slot_freed", 32'(out_valid), 32'd0);
      check("t2b_core_a", 32'(core_a), 32'h07);
      check("t2b_core_b", 32'(core_b), 32'h05);
      reply("t2b", 0);
      check("t2b_const", 32'(out_product), 32'h00000023);
      drain("t2b");

      // Accept in the same cycle the held result drains: launch is immediate.
      send("t3a", 8'hF8, 8'h10);
      wait_launch("t3a", 8'hF8, 8'h10, 0);
      reply("t3a", 3);
      out_ready = 1'b1;
      pop_compare("t3a");
      send("t3b", 8'hFF, 8'hFF);
      out_ready = 1'b0;
      check("t3b_direct_launch", 32'(core_valid), 32'd1);
      check("t3b_old_drained", 32'(out_valid), 32'd0);
      reply("t3b", 1);
      drain("t3b");

      // Spurious core_done in IDLE, with a held result and with an empty slot.
      send("t5", 8'h05, 8'hFD);
      wait_launch("t5", 8'h05, 8'hFD, 0);
      reply("t5", 0);
      core_done    = 1'b1;
      core_product = 16'hBEEF;
      tick();
      core_done    = 1'b0;
      check("t5_spur_valid", 32'(out_valid), 32'd1);
      check("t5_spur_busy", 32'(busy), 32'd0);
      drain("t5");
      core_done    = 1'b1;
      core_product = 16'hBEEF;
      tick();
      core_done    = 1'b0;
      check("t5_spur_empty", 32'(out_valid), 32'd0);

      // Reset in BUSY; a late core_done must not be captured.
      send("t4", 8'h04, 8'h04);
      wait_launch("t4", 8'h04, 8'h04, 0);
      tick();
      check("t4_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check("t4_rst_busy", 32'(busy), 32'd0);
      check("t4_rst_core_valid", 32'(core_valid), 32'd0);
      check("t4_rst_out_valid", 32'(out_valid), 32'd0);
      check("t4_rst_core_a", 32'(core_a), 32'd0);
      exp_q.delete();
      tick();
      rst = 1'b1;
      tick();
      core_done    = 1'b1;
      core_product = 16'h1234;
      tick();
      core_done    = 1'b0;
      check("t4_late_done_valid", 32'(out_valid), 32'd0);
      check("t4_late_done_product", 32'(out_product), 32'd0);
      check("t4_late_done_busy", 32'(busy), 32'd0);

      // Core never answers.
      send("t6", 8'h01, 8'h01);
      wait_launch("t6", 8'h01, 8'h01, 0);
      repeat (TIMEOUT) tick();
      check("t6_busy_at_16", 32'(busy), 32'd1);
      check("t6_no_err_yet", 32'(err), 32'd0);
      tick();
`ifdef BOOTH_IO_TIMEOUT_EN
      check("t6_timeout_idle", 32'(busy), 32'd0);
      check("t6_err", 32'(err), 32'd1);
      check("t6_in_ready", 32'(in_ready), 32'd1);
      check("t6_no_capture", 32'(out_valid), 32'd0);
      exp_q.delete();
      core_done    = 1'b1;
      core_product = 16'h0001;
      tick();
      core_done    = 1'b0;
      check("t6_late_ignored", 32'(out_valid), 32'd0);
      check("t6_err_sticky", 32'(err), 32'd1);
`else
      check("t6_still_busy", 32'(busy), 32'd1);
      check("t6_err_zero", 32'(err), 32'd0);
      repeat (20) tick();
      check("t6_still_busy_late", 32'(busy), 32'd1);
      core_done    = 1'b1;
      core_product = smul(core_a, core_b);
      tick();
      core_done    = 1'b0;
      drain("t6");
`endif

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
